// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Pipeline stage register with valid/ready handshake, flush, bubble output
// and an optional two-entry skid buffer.
//
// Parameters:
//   DATA_W  payload width
//   SKID    1: two entries, registered up_ready_o; 0: one entry, combinational ready
//   BUBBLE  value driven on dn_data_o while dn_valid_o=0
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush_i       squash held entries, discard same-cycle input
//   up_valid_i    producer has payload
//   up_data_i     producer payload
//   up_ready_o    stage can accept
//   dn_valid_o    stage holds a valid payload
//   dn_data_o     oldest held payload, or BUBBLE when empty
//   dn_ready_i    consumer accepts
//   occ_o         number of held entries (0..2)
module pipe_stage_skid #(
   parameter int unsigned          DATA_W = 32,
   parameter bit                   SKID   = 1'b1,
   parameter logic [DATA_W-1:0]    BUBBLE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              up_valid_i,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              up_ready_o,
   output logic              dn_valid_o,
   output logic [DATA_W-1:0] dn_data_o,
   input  logic              dn_ready_i,
   output logic [1:0]        occ_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              up_ready_q, up_ready_d;
   logic              up_xfer, dn_xfer;

   assign up_xfer = up_valid_i & up_ready_o;
   assign dn_xfer = dn_valid_o & dn_ready_i;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (up_xfer) begin
               state_d = ST_ONE;
               main_d  = up_data_i;
            end
         end
         ST_ONE: begin
            if (up_xfer && dn_xfer) begin
               main_d = up_data_i;
            end else if (up_xfer) begin
               // Without a skid register ready implies dn_ready_i here,
               // so this branch is reachable only when SKID=1.
               if (SKID) begin
                  state_d = ST_FULL;
                  skid_d  = up_data_i;
               end else begin
                  main_d = up_data_i;
               end
            end else if (dn_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (dn_xfer) begin
               state_d = ST_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush_i) state_d = ST_EMPTY;
      up_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         up_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         up_ready_q <= up_ready_d;
      end
      // Data registers are never cleared; the output mux hides stale contents.
      main_q <= main_d;
      skid_q <= skid_d;
   end

   assign up_ready_o = SKID ? up_ready_q : ((state_q == ST_EMPTY) | dn_ready_i);
   assign dn_valid_o = (state_q != ST_EMPTY);
   assign dn_data_o  = dn_valid_o ? main_q : BUBBLE;
   assign occ_o      = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

   localparam logic [31:0] BUB_A = 32'h0000_0013;
   localparam logic [31:0] BUB_B = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst;
   // instance A: SKID=1
   logic        a_flush, a_up_valid, a_up_ready, a_dn_valid, a_dn_ready;
   logic [31:0] a_up_data, a_dn_data;
   logic [1:0]  a_occ;
   // instance B: SKID=0
   logic        b_flush, b_up_valid, b_up_ready, b_dn_valid, b_dn_ready;
   logic [31:0] b_up_data, b_dn_data;
   logic [1:0]  b_occ;

   int vectors = 0;
   int errors  = 0;
   bit armed   = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(32), .SKID(1'b1), .BUBBLE(BUB_A)) u_a (
      .clk(clk), .rst(rst), .flush_i(a_flush),
      .up_valid_i(a_up_valid), .up_data_i(a_up_data), .up_ready_o(a_up_ready),
      .dn_valid_o(a_dn_valid), .dn_data_o(a_dn_data), .dn_ready_i(a_dn_ready),
      .occ_o(a_occ)
   );

   pipe_stage_skid #(.DATA_W(32), .SKID(1'b0), .BUBBLE(BUB_B)) u_b (
      .clk(clk), .rst(rst), .flush_i(b_flush),
      .up_valid_i(b_up_valid), .up_data_i(b_up_data), .up_ready_o(b_up_ready),
      .dn_valid_o(b_dn_valid), .dn_data_o(b_dn_data), .dn_ready_i(b_dn_ready),
      .occ_o(b_occ)
   );

   // Reference model: each stage is a bounded FIFO queue.
   logic [31:0] qa[$];
   logic [31:0] qb[$];

   function automatic logic model_ready(int size, int cap, logic dn_rdy);
      // Capacity 2 exposes "not full"; capacity 1 may also accept when the
      // held entry leaves in the same cycle.
      if (cap == 2) return size < 2;
      return (size == 0) || dn_rdy;
   endfunction

   always @(posedge clk) begin
      logic ua, da, ub, db;
      ua = a_up_valid && model_ready(qa.size(), 2, a_dn_ready);
      da = (qa.size() > 0) && a_dn_ready;
      ub = b_up_valid && model_ready(qb.size(), 1, b_dn_ready);
      db = (qb.size() > 0) && b_dn_ready;
      if (rst) begin
         qa.delete();
         qb.delete();
         armed = 1'b1;
      end else begin
         if (a_flush) qa.delete();
         else begin
            if (da) void'(qa.pop_front());
            if (ua) qa.push_back(a_up_data);
         end
         if (b_flush) qb.delete();
         else begin
            if (db) void'(qb.pop_front());
            if (ub) qb.push_back(b_up_data);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle once the model is meaningful.
   always @(negedge clk) begin
      if (armed) begin
         chk("a.valid", {31'd0, a_dn_valid}, {31'd0, qa.size() > 0});
         chk("a.data",  a_dn_data, (qa.size() > 0) ? qa[0] : BUB_A);
         chk("a.occ",   {30'd0, a_occ}, qa.size());
         chk("a.ready", {31'd0, a_up_ready}, {31'd0, model_ready(qa.size(), 2, a_dn_ready)});
         chk("b.valid", {31'd0, b_dn_valid}, {31'd0, qb.size() > 0});
         chk("b.data",  b_dn_data, (qb.size() > 0) ? qb[0] : BUB_B);
         chk("b.occ",   {30'd0, b_occ}, qb.size());
         chk("b.ready", {31'd0, b_up_ready}, {31'd0, model_ready(qb.size(), 1, b_dn_ready)});
      end
   end

   // One cycle of stimulus; returns at the following negedge.
   task automatic stepa(input logic r, input logic f, input logic v, input logic [31:0] d, input logic rdy);
      @(posedge clk); #1;
      rst = r; a_flush = f; a_up_valid = v; a_up_data = d; a_dn_ready = rdy;
      b_flush = 1'b0; b_up_valid = 1'b0; b_up_data = '0; b_dn_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic stepb(input logic f, input logic v, input logic [31:0] d, input logic rdy);
      @(posedge clk); #1;
      rst = 1'b0; b_flush = f; b_up_valid = v; b_up_data = d; b_dn_ready = rdy;
      a_flush = 1'b0; a_up_valid = 1'b0; a_up_data = '0; a_dn_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic lit_a(input string n, input logic v, input logic [31:0] d, input logic [1:0] o, input logic r);
      chk({n, ".valid"}, {31'd0, a_dn_valid}, {31'd0, v});
      chk({n, ".data"},  a_dn_data, d);
      chk({n, ".occ"},   {30'd0, a_occ}, {30'd0, o});
      chk({n, ".ready"}, {31'd0, a_up_ready}, {31'd0, r});
   endtask

   task automatic lit_b(input string n, input logic v, input logic [31:0] d, input logic [1:0] o, input logic r);
      chk({n, ".valid"}, {31'd0, b_dn_valid}, {31'd0, v});
      chk({n, ".data"},  b_dn_data, d);
      chk({n, ".occ"},   {30'd0, b_occ}, {30'd0, o});
      chk({n, ".ready"}, {31'd0, b_up_ready}, {31'd0, r});
   endtask

   initial begin
      rst = 1'b1;
      a_flush = 1'b0; a_up_valid = 1'b0; a_up_data = '0; a_dn_ready = 1'b0;
      b_flush = 1'b0; b_up_valid = 1'b0; b_up_data = '0; b_dn_ready = 1'b0;
      stepa(1, 0, 0, 0, 0);
      stepa(1, 0, 0, 0, 0);
      stepa(0, 0, 0, 0, 0);
      lit_a("reset_a", 0, BUB_A, 0, 1);
      lit_b("reset_b", 0, BUB_B, 0, 1);

      // Streaming, SKID=1
      stepa(0, 0, 1, 32'h11, 1);
      stepa(0, 0, 1, 32'h22, 1);  lit_a("stream1", 1, 32'h11, 1, 1);
      stepa(0, 0, 1, 32'h33, 1);  lit_a("stream2", 1, 32'h22, 1, 1);
      stepa(0, 0, 0, 0, 1);       lit_a("stream3", 1, 32'h33, 1, 1);
      stepa(0, 0, 0, 0, 1);       lit_a("drained", 0, BUB_A, 0, 1);

      // Backpressure into skid
      stepa(0, 0, 1, 32'hA, 0);
      stepa(0, 0, 1, 32'hB, 0);   lit_a("bp_one", 1, 32'hA, 1, 1);
      stepa(0, 0, 1, 32'hC, 0);   lit_a("bp_full", 1, 32'hA, 2, 0);
      stepa(0, 0, 1, 32'hC, 0);   lit_a("bp_hold", 1, 32'hA, 2, 0);
      stepa(0, 0, 1, 32'hC, 1);   lit_a("bp_out_a", 1, 32'hA, 2, 0);
      stepa(0, 0, 1, 32'hC, 1);   lit_a("bp_out_b", 1, 32'hB, 1, 1);
      stepa(0, 0, 0, 0, 1);       lit_a("bp_out_c", 1, 32'hC, 1, 1);
      stepa(0, 0, 0, 0, 1);       lit_a("bp_empty", 0, BUB_A, 0, 1);

      // Flush from FULL with coincident input
      stepa(0, 0, 1, 32'h1, 0);
      stepa(0, 0, 1, 32'h2, 0);
      stepa(0, 1, 1, 32'h3, 0);   lit_a("fl_pre", 1, 32'h1, 2, 0);
      stepa(0, 0, 0, 0, 1);       lit_a("fl_post", 0, BUB_A, 0, 1);
      stepa(0, 0, 0, 0, 1);       lit_a("fl_no3", 0, BUB_A, 0, 1);

      // Reset mid-stream with coincident input
      stepa(0, 0, 1, 32'h9, 0);
      stepa(1, 0, 1, 32'h8, 0);   lit_a("rs_pre", 1, 32'h9, 1, 1);
      stepa(0, 0, 1, 32'h7, 1);   lit_a("rs_post", 0, BUB_A, 0, 1);
      stepa(0, 0, 0, 0, 1);       lit_a("rs_push", 1, 32'h7, 1, 1);
      stepa(0, 0, 0, 0, 0);

      // SKID=0 combinational ready path
      stepb(0, 1, 32'h5, 0);      lit_b("s0_empty", 0, BUB_B, 0, 1);
      stepb(0, 0, 0, 0);          lit_b("s0_stall", 1, 32'h5, 1, 0);
      stepb(0, 1, 32'h6, 1);      lit_b("s0_ready", 1, 32'h5, 1, 1);
      stepb(0, 0, 0, 0);          lit_b("s0_repl", 1, 32'h6, 1, 0);
      stepb(0, 0, 0, 1);          lit_b("s0_drain", 1, 32'h6, 1, 1);
      stepb(0, 0, 0, 0);          lit_b("s0_empty2", 0, BUB_B, 0, 1);
      // SKID=0 flush with coincident U and D
      stepb(0, 1, 32'h4, 0);
      stepb(1, 1, 32'h9, 1);      lit_b("s0_flpre", 1, 32'h4, 1, 1);
      stepb(0, 0, 0, 0);          lit_b("s0_flpost", 0, BUB_B, 0, 1);
      // Back-to-back streaming, SKID=0
      stepb(0, 1, 32'h21, 1);
      stepb(0, 1, 32'h22, 1);     lit_b("s0_st1", 1, 32'h21, 1, 1);
      stepb(0, 0, 0, 1);          lit_b("s0_st2", 1, 32'h22, 1, 1);
      stepb(0, 0, 0, 0);          lit_b("s0_st3", 0, BUB_B, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshaking, flush (squash), bubble insertion and an optional 2-entry skid buffer. It replaces the fixed load-enable stage registers between IF/ID/EX/MEM/WB. Producer and consumer can stall independently, a branch redirect can kill in-flight work, and the optional skid buffer removes the combinational ready path between stages. The control word, operands and immediates are concatenated into one payload by the instantiating stage.

## Interface
Parameters:
- DATA_W, 32, payload width in bits (≥1)
- SKID, 1, 1 = two-entry skid buffer with registered up_ready_o; 0 = single register with combinational ready
- BUBBLE, '0 (DATA_W bits), value driven on dn_data_o whenever dn_valid_o=0 (e.g. NOP-encoded control word)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  squash all held entries; input in the same cycle is discarded
- up_valid_i  in  1  producer has payload
- up_data_i  in  DATA_W  producer payload
- up_ready_o  out  1  stage can accept; transfer when up_valid_i & up_ready_o
- dn_valid_o  out  1  stage holds valid payload for consumer
- dn_data_o  out  DATA_W  oldest held payload, or BUBBLE when empty
- dn_ready_i  in  1  consumer accepts; transfer when dn_valid_o & dn_ready_i
- occ_o  out  2  number of held entries (0..2; max 1 when SKID=0)

## Operation
- Storage: main register (head, drives dn_data_o) and, if SKID=1, skid register. FIFO order is always preserved.
- SKID=1 state machine (occupancy), with U = up transfer and D = down transfer:
  - EMPTY: U → ONE (main←up_data_i); else stay.
  - ONE: U&D → ONE (main←up_data_i); U only → FULL (skid←up_data_i); D only → EMPTY; neither → stay.
  - FULL: up_ready_o=0, so U is impossible; D → ONE (main←skid); else stay.
  - up_ready_o is a registered value: 1 exactly when the state is not FULL. There is no combinational path from dn_ready_i to up_ready_o.
- SKID=0:
  - up_ready_o = ~main_valid | dn_ready_i (combinational).
  - U loads main.
  - D without U clears main_valid.
- Flush (flush_i=1, any state):
  - Next state is EMPTY.
  - Any U in that cycle is discarded. up_ready_o may read 1; the producer treats the payload as consumed.
  - A D in that cycle still counts as delivered. The consumer side is not rolled back.
- Empty output: dn_data_o = BUBBLE whenever dn_valid_o=0. Data registers need not be cleared; only the output is muxed.
- Stability: while dn_valid_o=1 and dn_ready_i=0, dn_data_o and dn_valid_o hold constant, unless flush_i or rst is asserted.
- Producer-side rule: a valid payload may not be withdrawn before it is accepted. The block does not check this.
- occ_o equals the state encoding: EMPTY=0, ONE=1, FULL=2.

## Timing
- Reset: the cycle after rst=1 gives:
  - dn_valid_o=0
  - dn_data_o=BUBBLE
  - occ_o=0
  - up_ready_o=1
  
  Any U coincident with rst is discarded. rst has priority over flush_i and all transfers.
- Latency: a payload accepted at edge N appears on dn_data_o (dn_valid_o=1) after edge N, i.e. in cycle N+1. There is no same-cycle pass-through.
- Throughput: 1 transfer per cycle with dn_ready_i held high, for both SKID values.
- SKID=1 backpressure:
  - With dn_ready_i low, the stage absorbs at most 2 payloads.
  - up_ready_o drops in the cycle after the second accept.
  - up_ready_o returns to 1 in the cycle after the first D out of FULL.
- Flush mid-operation: in the cycle after flush_i the outputs are dn_valid_o=0, occ_o=0 and up_ready_o=1, from any state.
- Reset mid-operation: same result as flush. Payloads held in the stage are lost.

## Test plan
- Streaming: SKID=1, dn_ready_i=1, push 0x11,0x22,0x33 on consecutive cycles → dn_data_o shows 0x11,0x22,0x33 in cycles 2,3,4. up_ready_o stays 1 and occ_o stays 1.
- Backpressure/skid: SKID=1, dn_ready_i=0, offer 0xA,0xB,0xC every cycle →
  - 0xA and 0xB are accepted; occ_o=2; up_ready_o=0; 0xC is held by the producer.
  - Raise dn_ready_i → output order 0xA,0xB,0xC with no loss or duplication.
- SKID=0 ready path: main holds 0x5, dn_ready_i=0 → up_ready_o=0. Set dn_ready_i=1 → up_ready_o=1 in the same cycle, and 0x6 replaces 0x5 in the next cycle.
- Flush from FULL: occ_o=2 holding 0x1,0x2; assert flush_i together with up_valid_i carrying 0x3 → next cycle dn_valid_o=0, dn_data_o=BUBBLE, occ_o=0. 0x3 never appears.
- Bubble value: BUBBLE=32'h00000013, stage empty → dn_data_o=0x00000013 and dn_valid_o=0, both after reset and after draining.
- Reset mid-stream: SKID=1, occ_o=1, assert rst together with up_valid_i → next cycle occ_o=0, up_ready_o=1, dn_valid_o=0. A subsequent push of 0x7 emerges one cycle later.
